assoc2_kv_store: RTL and testbench
==================================

ASSOC2_KV_STORE -- requirements
Module: assoc2_kv_store

Interface
REQ-001 SHALL have parameter KEY1_W, default 32, outer key width.
REQ-002 SHALL have parameter KEY2_W, default 64, inner key width.
REQ-003 SHALL have parameter DATA_W, default 32, value width.
REQ-004 SHALL have parameter DEPTH, default 8, total (key1,key2) entries; legal range 2..64.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  block can accept a request.
REQ-009 SHALL have port req_op  input  2  00 READ, 01 WRITE, 10 EXISTS, 11 DELETE.
REQ-010 SHALL have port req_key1  input  KEY1_W  outer key.
REQ-011 SHALL have port req_key2  input  KEY2_W  inner key.
REQ-012 SHALL have port req_data  input  DATA_W  write value.
REQ-013 SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-014 SHALL have port rsp_hit  output  1  (key1,key2) was present before the operation.
REQ-015 SHALL have port rsp_err  output  1  WRITE dropped, store full.
REQ-016 SHALL have port rsp_data  output  DATA_W  READ result.
REQ-017 SHALL have port count  output  $clog2(DEPTH+1)  number of valid entries.

Function
REQ-018 SHALL implement FSM IDLE -> SCAN -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-019 SHALL accept a request on a posedge with req_valid&&req_ready, latching op, keys and data; inputs are ignored outside IDLE.
REQ-020 SHALL in SCAN examine one entry per cycle, index 0..DEPTH-1, recording first matching valid entry (both keys equal) and lowest-index free entry.
REQ-021 SHALL assert rsp_valid for exactly one cycle (RESP), DEPTH+1 cycles after the accepting edge; no response backpressure.
REQ-022 SHALL on READ hit return stored value; on miss return rsp_data=0 and rsp_hit=0, with no entry created.
REQ-023 SHALL on WRITE hit overwrite the value in place; on miss allocate the lowest free entry; with no free entry set rsp_err=1 and leave storage unchanged.
REQ-024 SHALL on EXISTS report rsp_hit only, rsp_data=0, no state change.
REQ-025 SHALL on DELETE hit clear the entry's valid bit; on miss change nothing; rsp_hit reports prior presence.
REQ-026 SHALL commit storage/valid/count updates on the edge entering RESP, so a request accepted right after RESP sees them.
REQ-027 SHALL keep rsp_hit, rsp_err, rsp_data at 0 whenever rsp_valid=0.
REQ-028 SHALL treat entries sharing key1 with different key2 as independent.
REQ-029 SHALL keep count within 0..DEPTH, tracking every allocation and delete.

Reset
REQ-030 SHALL on rst asynchronously clear all valid bits, count=0, FSM=IDLE, req_ready=1, rsp_valid/rsp_hit/rsp_err/rsp_data=0.
REQ-031 SHALL abort an in-flight request on rst with no response and no storage change; key/data storage need not be reset.

Structure
REQ-032 SHALL place the op encoding enum and FSM state enum in shared package assoc2_pkg.
REQ-033 SHALL isolate key/data/valid storage in one sub-module assoc2_entry_array (indexed read port, single write port, per-entry valid clear).

Verification
REQ-034 SHALL cover: WRITE (5,8)=8, WRITE (5,9)=9, READ both -> rsp_hit=1, rsp_data=8 then 9, count=2.
REQ-035 SHALL cover: READ (7,1) on empty store -> rsp_hit=0, rsp_data=0, count stays 0; rsp_valid exactly DEPTH+1 cycles after accept.
REQ-036 SHALL cover: fill DEPTH distinct keys, WRITE new key -> rsp_err=1, count=DEPTH; WRITE existing key value 'hAA -> rsp_err=0, READ returns 'hAA.
REQ-037 SHALL cover: DELETE (5,8) -> rsp_hit=1, count decrements, EXISTS (5,8) -> rsp_hit=0, EXISTS (5,9) -> rsp_hit=1.
REQ-038 SHALL cover: assert rst mid-SCAN of a WRITE -> no rsp_valid, req_ready=1 immediately, count=0, subsequent READ of that key misses.

Source files
------------

// File: rtl/assoc2_pkg.sv
// Shared encodings for the two-key associative store: request opcodes and controller states.
package assoc2_pkg;

  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_WRITE  = 2'b01,
    OP_EXISTS = 2'b10,
    OP_DELETE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/assoc2_entry_array.sv
// Key/value/valid storage: combinational indexed read, one write port that also sets valid, one valid-clear port.
// Zero-latency read; writes and clears land on the next posedge; no backpressure.
module assoc2_entry_array #(
  parameter int KEY1_W = 32,
  parameter int KEY2_W = 64,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [KEY1_W-1:0] rd_key1,
  output logic [KEY2_W-1:0] rd_key2,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [KEY1_W-1:0] wr_key1,
  input  logic [KEY2_W-1:0] wr_key2,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_en,
  input  logic [IDX_W-1:0]  clr_idx
);

  logic [DEPTH-1:0]  valid_q;
  logic [KEY1_W-1:0] key1_mem [DEPTH];
  logic [KEY2_W-1:0] key2_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  assign rd_valid = valid_q[rd_idx];
  assign rd_key1  = key1_mem[rd_idx];
  assign rd_key2  = key2_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (wr_en)  valid_q[wr_idx]  <= 1'b1;
      if (clr_en) valid_q[clr_idx] <= 1'b0;
    end
  end

  // Payload is only meaningful where valid is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      key1_mem[wr_idx] <= wr_key1;
      key2_mem[wr_idx] <= wr_key2;
      data_mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/assoc2_kv_store.sv
// Two-key associative store, linear scan of one entry per cycle; response strobe in the (DEPTH+1)th cycle after accept.
// req_ready only in IDLE (one request in flight); responses cannot be backpressured.
module assoc2_kv_store
  import assoc2_pkg::*;
#(
  parameter int KEY1_W = 32,
  parameter int KEY2_W = 64,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_op,
  input  logic [KEY1_W-1:0]          req_key1,
  input  logic [KEY2_W-1:0]          req_key2,
  input  logic [DATA_W-1:0]          req_data,
  output logic                       rsp_valid,
  output logic                       rsp_hit,
  output logic                       rsp_err,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  state_e             state_q, state_nxt;
  op_e                op_q;
  logic [KEY1_W-1:0]  key1_q;
  logic [KEY2_W-1:0]  key2_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [IDX_W-1:0]   idx_q;
  logic               hit_q, free_q;
  logic [IDX_W-1:0]   hit_idx_q, free_idx_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               rsp_hit_q, rsp_err_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic [CNT_W-1:0]   count_q;

  logic              rd_valid;
  logic [KEY1_W-1:0] rd_key1;
  logic [KEY2_W-1:0] rd_key2;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en, clr_en;
  logic [IDX_W-1:0]  wr_idx, clr_idx;
  logic              cnt_inc, cnt_dec, fin_err;

  // Scan results including the entry examined this cycle, used on the final scan cycle.
  logic              match, last, hit_fin, free_fin;
  logic [IDX_W-1:0]  hit_idx_fin, free_idx_fin;
  logic [DATA_W-1:0] rdata_fin;

  assign match        = rd_valid && (rd_key1 == key1_q) && (rd_key2 == key2_q);
  assign last         = (idx_q == IDX_W'(DEPTH-1));
  assign hit_fin      = hit_q || match;
  assign hit_idx_fin  = hit_q ? hit_idx_q : idx_q;
  assign rdata_fin    = hit_q ? rdata_q : rd_data;
  assign free_fin     = free_q || !rd_valid;
  assign free_idx_fin = free_q ? free_idx_q : idx_q;

  assoc2_entry_array #(
    .KEY1_W(KEY1_W), .KEY2_W(KEY2_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (idx_q),
    .rd_valid(rd_valid),
    .rd_key1 (rd_key1),
    .rd_key2 (rd_key2),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_key1 (key1_q),
    .wr_key2 (key2_q),
    .wr_data (wdata_q),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    req_ready = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = '0;
    clr_en    = 1'b0;
    clr_idx   = '0;
    cnt_inc   = 1'b0;
    cnt_dec   = 1'b0;
    fin_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (last) begin
          state_nxt = ST_RESP;
          case (op_q)
            OP_WRITE: begin
              if (hit_fin) begin
                wr_en  = 1'b1;
                wr_idx = hit_idx_fin;
              end else if (free_fin) begin
                wr_en   = 1'b1;
                wr_idx  = free_idx_fin;
                cnt_inc = 1'b1;
              end else begin
                fin_err = 1'b1;
              end
            end
            OP_DELETE: begin
              if (hit_fin) begin
                clr_en  = 1'b1;
                clr_idx = hit_idx_fin;
                cnt_dec = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= OP_READ;
      key1_q     <= '0;
      key2_q     <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
      free_q     <= 1'b0;
      free_idx_q <= '0;
      rdata_q    <= '0;
      rsp_hit_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
      count_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q    <= op_e'(req_op);
            key1_q  <= req_key1;
            key2_q  <= req_key2;
            wdata_q <= req_data;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            free_q  <= 1'b0;
          end
        end
        ST_SCAN: begin
          idx_q <= idx_q + IDX_W'(1);
          if (match && !hit_q) begin
            hit_q     <= 1'b1;
            hit_idx_q <= idx_q;
            rdata_q   <= rd_data;
          end
          if (!rd_valid && !free_q) begin
            free_q     <= 1'b1;
            free_idx_q <= idx_q;
          end
          if (last) begin
            rsp_hit_q  <= hit_fin;
            rsp_err_q  <= fin_err;
            rsp_data_q <= (op_q == OP_READ && hit_fin) ? rdata_fin : '0;
            if (cnt_inc) count_q <= count_q + CNT_W'(1);
            if (cnt_dec) count_q <= count_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_hit   = rsp_valid && rsp_hit_q;
  assign rsp_err   = rsp_valid && rsp_err_q;
  assign rsp_data  = rsp_valid ? rsp_data_q : '0;
  assign count     = count_q;

endmodule

// File: tb/tb_assoc2_kv_store.sv
// Directed bench for assoc2_kv_store: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_assoc2_kv_store;

  localparam int KEY1_W = 32;
  localparam int KEY2_W = 64;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH+1);

  localparam logic [1:0] RD = 2'b00, WR = 2'b01, EX = 2'b10, DL = 2'b11;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [KEY1_W-1:0] req_key1;
  logic [KEY2_W-1:0] req_key2;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid, rsp_hit, rsp_err;
  logic [DATA_W-1:0] rsp_data;
  logic [CNT_W-1:0]  count;

  assoc2_kv_store #(
    .KEY1_W(KEY1_W), .KEY2_W(KEY2_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_key1 (req_key1),
    .req_key2 (req_key2),
    .req_data (req_data),
    .rsp_valid(rsp_valid),
    .rsp_hit  (rsp_hit),
    .rsp_err  (rsp_err),
    .rsp_data (rsp_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          hit;
    bit          err;
    logic [31:0] data;
    int          cnt;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cycle  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_hit"},   64'(rsp_hit),  64'(e.hit));
          chk({e.name, "_err"},   64'(rsp_err),  64'(e.err));
          chk({e.name, "_data"},  64'(rsp_data), 64'(e.data));
          chk({e.name, "_count"}, 64'(count),    64'(e.cnt));
          // First cycle after the accepting edge counts as cycle 1.
          chk({e.name, "_latency"}, 64'(cycle - e.acc + 1), 64'(DEPTH + 1));
        end
      end else if (rsp_hit || rsp_err || rsp_data != '0) begin
        chk("idle_outputs_zero", {rsp_hit, rsp_err, rsp_data}, 64'd0);
      end
    end
  end

  task automatic do_req(input string name, input logic [1:0] op, input logic [31:0] k1,
                        input logic [63:0] k2, input logic [31:0] d,
                        input bit eh, input bit ee, input logic [31:0] ed, input int ec);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk({name, "_ready_timeout"}, 64'd0, 64'd1);
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_key1  = k1;
    req_key2  = k2;
    req_data  = d;
    @(posedge clk);
    #1;
    e.name = name; e.hit = eh; e.err = ee; e.data = ed; e.cnt = ec; e.acc = cycle;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < DEPTH + 10) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk({name, "_rsp_timeout"}, 64'd0, 64'd1);
      sb.delete();
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = RD;
    req_key1  = '0;
    req_key2  = '0;
    req_data  = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 64'(req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    rst = 1'b0;

    do_req("rd_empty",  RD, 7, 1, 0,     0, 0, 0, 0);
    do_req("wr_5_8",    WR, 5, 8, 8,     0, 0, 0, 1);
    do_req("wr_5_9",    WR, 5, 9, 9,     0, 0, 0, 2);
    do_req("rd_5_8",    RD, 5, 8, 0,     1, 0, 8, 2);
    do_req("rd_5_9",    RD, 5, 9, 0,     1, 0, 9, 2);
    do_req("ex_5_8",    EX, 5, 8, 0,     1, 0, 0, 2);
    for (int i = 0; i < DEPTH - 2; i++)
      do_req("fill", WR, 1, 64'(i), 32'(100 + i), 0, 0, 0, 3 + i);
    do_req("wr_full",   WR, 2, 2, 32'h77, 0, 1, 0, DEPTH);
    do_req("rd_dropped", RD, 2, 2, 0,    0, 0, 0, DEPTH);
    do_req("wr_over",   WR, 5, 8, 32'hAA, 1, 0, 0, DEPTH);
    do_req("rd_over",   RD, 5, 8, 0,     1, 0, 32'hAA, DEPTH);
    do_req("rd_fill3",  RD, 1, 3, 0,     1, 0, 103, DEPTH);
    do_req("del_5_8",   DL, 5, 8, 0,     1, 0, 0, DEPTH - 1);
    do_req("ex_del",    EX, 5, 8, 0,     0, 0, 0, DEPTH - 1);
    do_req("ex_5_9",    EX, 5, 9, 0,     1, 0, 0, DEPTH - 1);
    do_req("del_miss",  DL, 5, 8, 0,     0, 0, 0, DEPTH - 1);
    do_req("wr_reuse",  WR, 9, 9, 32'h55, 0, 0, 0, DEPTH);
    do_req("rd_reuse",  RD, 9, 9, 0,     1, 0, 32'h55, DEPTH);

    // Reset in the middle of a WRITE scan: no response may follow.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = WR;
    req_key1  = 3;
    req_key2  = 3;
    req_data  = 32'h33;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midscan_rst_ready", 64'(req_ready), 64'd1);
    chk("midscan_rst_count", 64'(count), 64'd0);
    chk("midscan_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (DEPTH + 4) @(negedge clk);
    do_req("rd_aborted", RD, 3, 3, 0,    0, 0, 0, 0);
    do_req("rd_after_rst", RD, 5, 9, 0,  0, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
